// File: rtl/gray_step_ctrl.sv
// gray_step_ctrl: steps a binary position up/down on command and presents it as registered Gray code
module gray_step_ctrl #(
    parameter int DATA_WIDTH = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_dir,
    input  logic [CNT_WIDTH-1:0]  cmd_steps,
    input  logic                  abort,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  busy,
    output logic                  done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] pos, pos_nxt;
    logic [CNT_WIDTH-1:0]  rem, rem_nxt;
    logic                  dir, dir_nxt;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            pos   <= '0;
            rem   <= '0;
            dir   <= 1'b0;
            out   <= '0;
        end else begin
            state <= state_nxt;
            pos   <= pos_nxt;
            rem   <= rem_nxt;
            dir   <= dir_nxt;
            out   <= pos_nxt ^ (pos_nxt >> 1);
        end
    end
    always_comb begin
        state_nxt = state;
        pos_nxt   = pos;
        rem_nxt   = rem;
        dir_nxt   = dir;
        case (state)
            IDLE: if (cmd_valid) begin
                dir_nxt   = cmd_dir;
                rem_nxt   = cmd_steps;
                state_nxt = (cmd_steps != '0) ? RUN : DONE;
            end
            RUN: if (abort) begin
                rem_nxt   = '0;
                state_nxt = DONE;
            end else begin
                pos_nxt   = dir ? pos + 1'b1 : pos - 1'b1;
                rem_nxt   = rem - 1'b1;
                state_nxt = (rem == CNT_WIDTH'(1)) ? DONE : RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end
    assign cmd_ready = (state == IDLE);
    assign busy      = (state == RUN);
    assign done      = (state == DONE);
endmodule

// File: tb/tb_gray_step_ctrl.sv
// tb_gray_step_ctrl: random and directed step commands checked against a position-tracking model
module tb_gray_step_ctrl;
    localparam int DW = 4;
    localparam int CW = 8;
    logic          clk = 1'b0;
    logic          resetn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_dir;
    logic [CW-1:0] cmd_steps;
    logic          abort;
    logic [DW-1:0] out;
    logic          busy;
    logic          done;
    int            pos;
    int            n_tests = 0;
    int            n_fail  = 0;

    gray_step_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .abort(abort),
        .out(out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic int gray(input int p);
        return (p ^ (p >> 1)) & ((1 << DW) - 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // one full command; ab = RUN edge (1-based) where abort is raised, 0 = never
    task automatic run_cmd(input logic d, input int steps, input int ab, input bit hold);
        chk("pre_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_dir   = d;
        cmd_steps = CW'(steps);
        abort     = 1'b0;
        tick;
        cmd_valid = hold;
        cmd_dir   = 1'($urandom);
        cmd_steps = CW'($urandom);
        chk("acc_out", out, gray(pos));
        chk("acc_busy", busy, steps > 0);
        chk("acc_done", done, steps == 0);
        chk("acc_ready", cmd_ready, 0);
        for (int j = 1; j <= steps; j++) begin
            abort = (j == ab);
            tick;
            abort = 1'b0;
            cmd_steps = CW'($urandom);
            if (j == ab) begin
                chk("abort_out", out, gray(pos));
                chk("abort_done", done, 1);
                chk("abort_busy", busy, 0);
                break;
            end
            pos = (pos + (d ? 1 : (1 << DW) - 1)) % (1 << DW);
            chk("step_out", out, gray(pos));
            chk("step_busy", busy, j < steps);
            chk("step_done", done, j == steps);
        end
        abort = 1'($urandom);
        tick;
        abort = 1'b0;
        chk("idle_ready", cmd_ready, 1);
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_out", out, gray(pos));
    endtask

    initial begin
        resetn    = 1'b0;
        cmd_valid = 1'b0;
        cmd_dir   = 1'b0;
        cmd_steps = '0;
        abort     = 1'b0;
        pos       = 0;
        #1;
        chk("rst_out", out, 0);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        repeat (2) tick;
        resetn = 1'b1;
        run_cmd(1'b1, 3, 0, 1'b0);
        pos = 0;
        resetn = 1'b0;
        #1;
        resetn = 1'b1;
        tick;
        cmd_valid = 1'b1;
        cmd_dir   = 1'b1;
        cmd_steps = CW'(5);
        tick;
        cmd_valid = 1'b0;
        repeat (2) tick;
        chk("mid_out", out, gray(2));
        chk("mid_busy", busy, 1);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_out", out, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_ready", cmd_ready, 1);
        repeat (3) begin
            tick;
            chk("arst_nodone", done, 0);
            chk("arst_hold", out, 0);
        end
        resetn = 1'b1;
        pos = 0;
        run_cmd(1'b0, 1, 0, 1'b0);
        chk("wrap_low", out, 4'b1000);
        run_cmd(1'b1, 1, 0, 1'b0);
        chk("wrap_up", out, 4'b0000);
        run_cmd(1'b0, 1, 0, 1'b0);
        chk("wrap_dn", out, 4'b1000);
        run_cmd(1'b1, 0, 0, 1'b0);
        run_cmd(1'b1, 1, 0, 1'b0);
        run_cmd(1'b1, 5, 3, 1'b0);
        chk("abort_pos", out, 4'b0011);
        run_cmd(1'b0, 4, 0, 1'b1);
        run_cmd(1'b1, 2, 0, 1'b1);
        run_cmd(1'b1, 2, 4, 1'b0);
        for (int k = 0; k < 40; k++) begin
            int s, a;
            s = $urandom_range(0, 20);
            a = (s > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, s) : 0;
            run_cmd(1'($urandom), s, a, 1'($urandom));
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/gray_step_ctrl.md
GRAY_STEP_CTRL -- requirements
Module: gray_step_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 4, SHALL set the width of the Gray-coded position output.
REQ-002 Parameter CNT_WIDTH, default 8, SHALL set the width of the step-count field.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 resetn  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 cmd_valid  input  1  SHALL indicate that a step command is offered.
REQ-006 cmd_ready  output  1  SHALL indicate the block can accept a command.
REQ-007 cmd_dir  input  1  SHALL select direction: 1 = up (+1), 0 = down (-1).
REQ-008 cmd_steps  input  CNT_WIDTH  SHALL give the number of steps to execute.
REQ-009 abort  input  1  SHALL request early termination of a running command.
REQ-010 out  output  DATA_WIDTH  SHALL be the registered Gray code of the internal position.
REQ-011 busy  output  1  SHALL be high while a command is stepping.
REQ-012 done  output  1  SHALL pulse high for exactly one cycle when a command completes.

Function
REQ-013 The block SHALL keep an internal DATA_WIDTH-bit binary position pos; out SHALL equal pos ^ (pos >> 1), registered and updated on the same edge as pos.
REQ-014 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-015 cmd_ready SHALL be 1 only in IDLE; busy SHALL be 1 only in RUN; done SHALL be 1 only in DONE; all three SHALL be decoded from registered state.
REQ-016 A command SHALL be accepted on a rising edge where cmd_valid && cmd_ready; cmd_dir and cmd_steps SHALL be captured on that edge.
REQ-017 On acceptance with cmd_steps > 0: remaining <= cmd_steps, state <= RUN; pos SHALL NOT change on the acceptance edge.
REQ-018 On acceptance with cmd_steps == 0: state <= DONE; pos unchanged.
REQ-019 In RUN with abort low, each edge SHALL step pos by ±1 per captured direction and decrement remaining; if remaining == 1 on that edge, state <= DONE.
REQ-020 Therefore a command of N > 0 steps SHALL change out on the N consecutive edges after the acceptance edge, with done high in the following cycle.
REQ-021 Wrap-around: up from 2^DATA_WIDTH-1 SHALL yield 0; down from 0 SHALL yield 2^DATA_WIDTH-1.
REQ-022 In RUN, abort high at an edge SHALL take priority: no step on that edge, state <= DONE.
REQ-023 abort SHALL be ignored in IDLE and DONE.
REQ-024 DONE SHALL last one cycle, then state <= IDLE unconditionally.
REQ-025 Changes on cmd_dir, cmd_steps or cmd_valid outside the acceptance edge SHALL have no effect.
REQ-026 pos SHALL persist between commands; the next command continues from the current position.

Reset
REQ-027 resetn low SHALL immediately (asynchronously) force pos = 0, out = 0, remaining = 0, state = IDLE, busy = 0, done = 0, cmd_ready = 1, including mid-RUN.
REQ-028 After resetn deasserts, the first command SHALL be acceptable on the first rising edge.

Verification
REQ-029 Reset mid-RUN: 5-step up command, resetn low after 2 steps -> out = 0000, busy = 0, done = 0 without waiting for a clock edge; no done pulse follows.
REQ-030 Up count from reset: cmd_steps = 3, cmd_dir = 1 -> out 0001, 0011, 0010 on three successive edges; done = 1 for one cycle; then cmd_ready = 1.
REQ-031 Wrap: position at 15 (out 1000), 1 step up -> out 0000; then 1 step down -> out 1000.
REQ-032 Zero steps: cmd_steps = 0 accepted -> done = 1 next cycle, out unchanged, busy never high.
REQ-033 Abort: 5-step up command from 0, abort high on the third RUN edge -> out stays 0011, done = 1 next cycle, remaining steps discarded.
REQ-034 Backpressure: cmd_valid held high during RUN -> cmd_ready = 0, not accepted; accepted on the first edge after DONE returns to IDLE, with the values present on that edge.
